counter_bank: RTL and testbench

//  Multi-channel event-counter bank: NUM_CH independent WIDTH-bit accumulators, each adding a
//  per-channel increment when enabled, with per-channel wrap/saturate mode and sticky overflow.
//  An atomic snapshot captures all channels in one cycle and streams them out serially over a

---
 rtl/counter_bank_pkg.sv | 22 ++
 rtl/counter_bank_chan.sv | 57 +++++
 rtl/counter_bank.sv | 134 +++++++++++++
 tb/tb_counter_bank.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_bank_pkg.sv
// ============================================================================
// Module  : counter_bank_pkg
// Brief   : Shared types and helpers for the counter bank.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_bank_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DUMP = 1'b1
    } state_t;

    // Channel-index width; a single-channel bank still gets a 1-bit index.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/counter_bank_chan.sv
// ============================================================================
// Module  : counter_chan
// Brief   : One accumulator channel with wrap/saturate, sticky overflow,
//           synchronous clear and snapshot clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_chan #(
    parameter int WIDTH    = 16,
    parameter int IN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [IN_WIDTH-1:0] inc,
    input  logic                sat_mode,
    input  logic                clr,
    input  logic                snap_clr,
    output logic [WIDTH-1:0]    cnt,
    output logic                ovf
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_ovf;
    logic [WIDTH-1:0] w_base;
    logic             w_base_ovf;
    logic [WIDTH:0]   w_sum;

    // On a snapshot clear the increment lands on a zero base, so nothing is
    // lost between the captured value and the restarted counter.
    assign w_base     = snap_clr ? '0 : r_cnt;
    assign w_base_ovf = snap_clr ? 1'b0 : r_ovf;
    assign w_sum      = {1'b0, w_base} + {{(WIDTH + 1 - IN_WIDTH){1'b0}}, inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else if (en) begin
            r_cnt <= (sat_mode && w_sum[WIDTH]) ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
            r_ovf <= w_base_ovf | w_sum[WIDTH];
        end else if (snap_clr) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end
    end

    assign cnt = r_cnt;
    assign ovf = r_ovf;

endmodule

`default_nettype wire

// File: rtl/counter_bank.sv
// ============================================================================
// Module  : counter_bank
// Brief   : NUM_CH event counters with atomic snapshot and serial
//           valid/ready readout of the captured values.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int WIDTH         = 16,
    parameter int IN_WIDTH      = 8,
    parameter int CLEAR_ON_SNAP = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CH-1:0]                  en,
    input  logic [NUM_CH*IN_WIDTH-1:0]         inc,
    input  logic [NUM_CH-1:0]                  sat_mode,
    input  logic [NUM_CH-1:0]                  clr,
    input  logic                               snap_req,
    output logic                               snap_busy,
    output logic [NUM_CH*WIDTH-1:0]            cnt,
    output logic [NUM_CH-1:0]                  ovf,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_data,
    output logic [ch_width(NUM_CH)-1:0]        out_ch,
    output logic                               out_ovf,
    output logic                               out_last
);

    localparam int              c_CH_W    = ch_width(NUM_CH);
    localparam logic [c_CH_W-1:0] c_LAST_CH = c_CH_W'(NUM_CH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [c_CH_W-1:0] r_out_ch;
    logic [c_CH_W-1:0] w_out_ch_nxt;
    logic [WIDTH-1:0]  r_shadow_cnt [NUM_CH];
    logic [NUM_CH-1:0] r_shadow_ovf;
    logic              w_capture;
    logic              w_snap_clr;
    logic              w_dumping;
    logic              w_at_last;

    assign w_dumping  = (r_state == ST_DUMP);
    assign w_capture  = snap_req && (r_state == ST_IDLE);
    assign w_snap_clr = (CLEAR_ON_SNAP != 0) && w_capture;
    assign w_at_last  = (r_out_ch == c_LAST_CH);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            counter_chan #(
                .WIDTH    (WIDTH),
                .IN_WIDTH (IN_WIDTH)
            ) u_chan (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (en[gi]),
                .inc      (inc[gi*IN_WIDTH +: IN_WIDTH]),
                .sat_mode (sat_mode[gi]),
                .clr      (clr[gi]),
                .snap_clr (w_snap_clr),
                .cnt      (cnt[gi*WIDTH +: WIDTH]),
                .ovf      (ovf[gi])
            );
        end
    endgenerate

    // The channel outputs are registered, so they hold the pre-update values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow_cnt[i] <= '0;
            end
            r_shadow_ovf <= '0;
        end else if (w_capture) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_shadow_cnt[i] <= cnt[i*WIDTH +: WIDTH];
            end
            r_shadow_ovf <= ovf;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_out_ch <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_out_ch <= w_out_ch_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_out_ch_nxt = r_out_ch;
        case (r_state)
            ST_IDLE: begin
                if (snap_req) begin
                    w_state_nxt  = ST_DUMP;
                    w_out_ch_nxt = '0;
                end
            end
            ST_DUMP: begin
                if (out_ready) begin
                    if (w_at_last) begin
                        w_state_nxt  = ST_IDLE;
                        w_out_ch_nxt = '0;
                    end else begin
                        w_out_ch_nxt = r_out_ch + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_out_ch_nxt = '0;
            end
        endcase
    end

    assign snap_busy = w_dumping;
    assign out_valid = w_dumping;
    assign out_ch    = r_out_ch;
    assign out_data  = w_dumping ? r_shadow_cnt[r_out_ch] : '0;
    assign out_ovf   = w_dumping ? r_shadow_ovf[r_out_ch] : 1'b0;
    assign out_last  = w_dumping && w_at_last;

endmodule

`default_nettype wire

// File: tb/tb_counter_bank.sv
// ============================================================================
// Module  : tb_counter_bank
// Brief   : Bench for counter_bank; one instance per snapshot-clear mode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_counter_bank;

    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int IW  = 8;
    localparam int MAXV = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  en = '0;
    logic [31:0] inc = '0;
    logic [3:0]  sat_mode = '0;
    logic [3:0]  clr = '0;
    logic        snap_req = 1'b0;
    logic        out_ready = 1'b0;

    logic        snap_busy_o [2];
    logic [31:0] cnt_o       [2];
    logic [3:0]  ovf_o       [2];
    logic        out_valid_o [2];
    logic [7:0]  out_data_o  [2];
    logic [1:0]  out_ch_o    [2];
    logic        out_ovf_o   [2];
    logic        out_last_o  [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    counter_bank #(.NUM_CH(NCH), .WIDTH(W), .IN_WIDTH(IW), .CLEAR_ON_SNAP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .inc(inc), .sat_mode(sat_mode), .clr(clr),
        .snap_req(snap_req), .snap_busy(snap_busy_o[0]), .cnt(cnt_o[0]), .ovf(ovf_o[0]),
        .out_valid(out_valid_o[0]), .out_ready(out_ready), .out_data(out_data_o[0]),
        .out_ch(out_ch_o[0]), .out_ovf(out_ovf_o[0]), .out_last(out_last_o[0])
    );

    counter_bank #(.NUM_CH(NCH), .WIDTH(W), .IN_WIDTH(IW), .CLEAR_ON_SNAP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .inc(inc), .sat_mode(sat_mode), .clr(clr),
        .snap_req(snap_req), .snap_busy(snap_busy_o[1]), .cnt(cnt_o[1]), .ovf(ovf_o[1]),
        .out_valid(out_valid_o[1]), .out_ready(out_ready), .out_data(out_data_o[1]),
        .out_ch(out_ch_o[1]), .out_ovf(out_ovf_o[1]), .out_last(out_last_o[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain integer counters, a captured copy and a word index.
    int m_cnt    [2][4];
    bit m_ovf    [2][4];
    int m_sh     [2][4];
    bit m_sh_ovf [2][4];
    bit m_busy   [2];
    int m_ch     [2];

    // Returns next count + 256 * next overflow for instance k, channel c.
    function automatic int model_next(input int k, input int c);
        bit wipe;
        int base;
        int s;
        bit o;
        wipe = (k == 1) && snap_req && !m_busy[k];
        base = wipe ? 0 : m_cnt[k][c];
        o    = wipe ? 1'b0 : m_ovf[k][c];
        if (clr[c]) return 0;
        if (en[c]) begin
            s = base + int'(inc[c*8 +: 8]);
            if (s > MAXV) return 256 + (sat_mode[c] ? MAXV : s - 256);
            return (o ? 256 : 0) + s;
        end
        if (wipe) return 0;
        return (m_ovf[k][c] ? 256 : 0) + m_cnt[k][c];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 4; c++) begin
                    m_cnt[k][c]    <= 0;
                    m_ovf[k][c]    <= 1'b0;
                    m_sh[k][c]     <= 0;
                    m_sh_ovf[k][c] <= 1'b0;
                end
                m_busy[k] <= 1'b0;
                m_ch[k]   <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 4; c++) begin
                    m_cnt[k][c] <= model_next(k, c) % 256;
                    m_ovf[k][c] <= (model_next(k, c) >= 256);
                end
                if (snap_req && !m_busy[k]) begin
                    for (int c = 0; c < 4; c++) begin
                        m_sh[k][c]     <= m_cnt[k][c];
                        m_sh_ovf[k][c] <= m_ovf[k][c];
                    end
                    m_busy[k] <= 1'b1;
                    m_ch[k]   <= 0;
                end else if (m_busy[k] && out_ready) begin
                    if (m_ch[k] == NCH - 1) begin
                        m_busy[k] <= 1'b0;
                        m_ch[k]   <= 0;
                    end else begin
                        m_ch[k] <= m_ch[k] + 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 4; c++) begin
                    chk($sformatf("cnt i%0d ch%0d", k, c), int'(cnt_o[k][c*8 +: 8]), m_cnt[k][c]);
                    chk($sformatf("ovf i%0d ch%0d", k, c), int'(ovf_o[k][c]), int'(m_ovf[k][c]));
                end
                chk($sformatf("snap_busy i%0d", k), int'(snap_busy_o[k]), int'(m_busy[k]));
                chk($sformatf("out_valid i%0d", k), int'(out_valid_o[k]), int'(m_busy[k]));
                chk($sformatf("out_ch i%0d", k), int'(out_ch_o[k]), m_ch[k]);
                chk($sformatf("out_data i%0d", k), int'(out_data_o[k]),
                    m_busy[k] ? m_sh[k][m_ch[k]] : 0);
                chk($sformatf("out_ovf i%0d", k), int'(out_ovf_o[k]),
                    m_busy[k] ? int'(m_sh_ovf[k][m_ch[k]]) : 0);
                chk($sformatf("out_last i%0d", k), int'(out_last_o[k]),
                    int'(m_busy[k] && m_ch[k] == NCH - 1));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int got;
        bit rdy;
        int words;

        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("reset cnt", int'(cnt_o[k]), 0);
            chk("reset ovf", int'(ovf_o[k]), 0);
            chk("reset out_valid", int'(out_valid_o[k]), 0);
            chk("reset snap_busy", int'(snap_busy_o[k]), 0);
            chk("reset out_ch", int'(out_ch_o[k]), 0);
            chk("reset out_data", int'(out_data_o[k]), 0);
            chk("reset out_last", int'(out_last_o[k]), 0);
        end
        rst_n = 1'b1;
        tick();

        // Wrap on channel 0
        en = 4'b0001; inc = 32'd250;
        tick();
        inc = 32'd10;
        tick();
        en = '0;
        chk("wrap cnt", int'(cnt_o[0][7:0]), 4);
        chk("wrap ovf", int'(ovf_o[0][0]), 1);

        // Saturate on channel 1
        sat_mode = 4'b0010; en = 4'b0010; inc = 32'd250 << 8;
        tick();
        inc = 32'd10 << 8;
        tick();
        chk("sat cnt", int'(cnt_o[0][15:8]), 255);
        chk("sat ovf", int'(ovf_o[0][1]), 1);
        inc = 32'd3 << 8;
        tick();
        chk("sat hold", int'(cnt_o[0][15:8]), 255);
        en = '0;

        // Clear beats enable on channel 2
        en = 4'b0100; inc = 32'd9 << 16;
        tick();
        clr = 4'b0100; inc = 32'd5 << 16;
        tick();
        clr = '0; en = '0;
        chk("clr cnt", int'(cnt_o[0][23:16]), 0);
        chk("clr ovf", int'(ovf_o[0][2]), 0);
        chk("clr other ch0", int'(cnt_o[0][7:0]), 4);
        chk("clr other ch1", int'(cnt_o[0][15:8]), 255);

        // Dump with backpressure
        clr = 4'hf;
        tick();
        clr = '0; en = 4'hf; inc = 32'h04030201;
        tick();
        en = '0; snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        chk("snap latency", int'(out_valid_o[0]), 1);
        chk("snap clear live", int'(cnt_o[1]), 0);
        chk("snap keep live", int'(cnt_o[0]), 32'h04030201);
        got = 0; rdy = 1'b1;
        for (int i = 0; i < 20 && out_valid_o[0]; i++) begin
            out_ready = rdy;
            chk("dump data", int'(out_data_o[0]), got + 1);
            chk("dump data cos", int'(out_data_o[1]), got + 1);
            chk("dump ch", int'(out_ch_o[0]), got);
            chk("dump last", int'(out_last_o[0]), int'(got == 3));
            if (rdy) got++;
            tick();
            rdy = !rdy;
        end
        out_ready = 1'b0;
        chk("dump words", got, 4);
        chk("dump done", int'(snap_busy_o[0]), 0);

        // Snapshot clear keeps the increment; a second request mid-dump is ignored
        clr = 4'hf;
        tick();
        clr = '0; en = 4'b0001; inc = 32'd7;
        tick();
        inc = 32'd2; snap_req = 1'b1;
        tick();
        en = '0;
        chk("cos live", int'(cnt_o[1][7:0]), 2);
        chk("nocos live", int'(cnt_o[0][7:0]), 9);
        chk("cos captured", int'(out_data_o[1]), 7);
        chk("nocos captured", int'(out_data_o[0]), 7);
        out_ready = 1'b1;
        words = 0;
        for (int i = 0; i < 12 && out_valid_o[1]; i++) begin
            words++;
            tick();
        end
        snap_req = 1'b0; out_ready = 1'b0;
        chk("cos words", words, 4);
        chk("cos idle", int'(snap_busy_o[1]), 0);
        tick();

        // Reset in the middle of a dump
        en = 4'hf; inc = 32'h11223344; snap_req = 1'b1;
        tick();
        snap_req = 1'b0; en = '0; out_ready = 1'b1;
        tick();
        tick();
        chk("mid ch", int'(out_ch_o[0]), 2);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("abort valid", int'(out_valid_o[k]), 0);
            chk("abort busy", int'(snap_busy_o[k]), 0);
            chk("abort cnt", int'(cnt_o[k]), 0);
            chk("abort ch", int'(out_ch_o[k]), 0);
        end
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            en = 4'($urandom);
            inc = $urandom;
            if ($urandom_range(0, 15) == 0) sat_mode = 4'($urandom);
            clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0;
            snap_req = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        en = '0; clr = '0; snap_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
